// File: rtl/fault_map_collector.sv
// Collects DLC diagnosis results row by row into a per-PE fault map and streams it to eNVM/BISR.
// Optional macro FAULT_MAP_PARITY_EN adds a registered even-parity bit alongside each written pattern.
module fault_map_collector #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
    parameter int CNT_WIDTH     = $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     detection_en,
    output logic [ADDR_WIDTH-1:0]    detection_addr,
    input  logic [SYSTOLIC_SIZE-1:0] single_pe_detection,
    input  logic                     row_fault_detection,
    input  logic [SYSTOLIC_SIZE-1:0] column_fault_detection,
    output logic                     envm_wr_en,
    output logic [ADDR_WIDTH-1:0]    envm_wr_addr,
    output logic [SYSTOLIC_SIZE-1:0] envm_faulty_pattern,
    output logic                     envm_pattern_parity,
    output logic [CNT_WIDTH-1:0]     fault_count,
    output logic                     row_all_faulty,
    output logic                     busy,
    output logic                     collect_done
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPTURE,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   row;
    logic [SYSTOLIC_SIZE-1:0] fault_map [SYSTOLIC_SIZE];
    logic [SYSTOLIC_SIZE-1:0] captured_row;

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [SYSTOLIC_SIZE-1:0] v);
        logic [CNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
            n = n + CNT_WIDTH'(v[i]);
        end
        return n;
    endfunction

    // A whole-row fault or a column fault marks every affected PE in the row.
    assign captured_row = single_pe_detection | column_fault_detection
                        | {SYSTOLIC_SIZE{row_fault_detection}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            row                 <= '0;
            detection_en        <= 1'b0;
            detection_addr      <= '0;
            envm_wr_en          <= 1'b0;
            envm_wr_addr        <= '0;
            envm_faulty_pattern <= '0;
            fault_count         <= '0;
            row_all_faulty      <= 1'b0;
            busy                <= 1'b0;
            collect_done        <= 1'b0;
            // NOTE: the map is reset on purpose so an aborted run can never leak stale rows;
            // a plain storage array would normally be left unreset.
            for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
                fault_map[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
            collect_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= REQ;
                        row            <= '0;
                        detection_en   <= 1'b1;
                        detection_addr <= '0;
                        fault_count    <= '0;
                        row_all_faulty <= 1'b0;
                        busy           <= 1'b1;
                        for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
                            fault_map[i] <= '0;
                        end
                    end
                end

                REQ: begin
                    detection_en <= 1'b0;
                    state        <= CAPTURE;
                end

                CAPTURE: begin
                    fault_map[row] <= captured_row;
                    if (row == LAST_ROW) begin
                        row   <= '0;
                        state <= WRITE;
                    end else begin
                        row            <= row + 1'b1;
                        detection_en   <= 1'b1;
                        detection_addr <= row + 1'b1;
                        state          <= REQ;
                    end
                end

                WRITE: begin
                    envm_wr_en          <= 1'b1;
                    envm_wr_addr        <= row;
                    envm_faulty_pattern <= fault_map[row];
                    fault_count         <= fault_count + popcount(fault_map[row]);
                    if (&fault_map[row]) begin
                        row_all_faulty <= 1'b1;
                    end
                    if (row == LAST_ROW) begin
                        row   <= '0;
                        state <= DONE;
                    end else begin
                        row <= row + 1'b1;
                    end
                end

                DONE: begin
                    envm_wr_en          <= 1'b0;
                    envm_wr_addr        <= '0;
                    envm_faulty_pattern <= '0;
                    collect_done        <= 1'b1;
                    busy                <= 1'b0;
                    state               <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FAULT_MAP_PARITY_EN
    // Parity tracks the pattern register edge for edge, so it is 0 whenever no write is driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            envm_pattern_parity <= 1'b0;
        end else if (state == WRITE) begin
            envm_pattern_parity <= ^fault_map[row];
        end else begin
            envm_pattern_parity <= 1'b0;
        end
    end
`else
    assign envm_pattern_parity = 1'b0;
`endif

endmodule

// File: tb/tb_fault_map_collector.sv
// Directed bench for fault_map_collector: a DLC responder, a map-level reference model,
// and a per-cycle compare process on the negative edge.
module tb_fault_map_collector;

    localparam int N   = 8;
    localparam int AW  = 3;
    localparam int CW  = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          detection_en;
    logic [AW-1:0] detection_addr;
    logic [N-1:0]  single_pe_detection;
    logic          row_fault_detection;
    logic [N-1:0]  column_fault_detection;
    logic          envm_wr_en;
    logic [AW-1:0] envm_wr_addr;
    logic [N-1:0]  envm_faulty_pattern;
    logic          envm_pattern_parity;
    logic [CW-1:0] fault_count;
    logic          row_all_faulty;
    logic          busy;
    logic          collect_done;

    fault_map_collector #(.SYSTOLIC_SIZE(N)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .start                  (start),
        .detection_en           (detection_en),
        .detection_addr         (detection_addr),
        .single_pe_detection    (single_pe_detection),
        .row_fault_detection    (row_fault_detection),
        .column_fault_detection (column_fault_detection),
        .envm_wr_en             (envm_wr_en),
        .envm_wr_addr           (envm_wr_addr),
        .envm_faulty_pattern    (envm_faulty_pattern),
        .envm_pattern_parity    (envm_pattern_parity),
        .fault_count            (fault_count),
        .row_all_faulty         (row_all_faulty),
        .busy                   (busy),
        .collect_done           (collect_done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // DLC stand-in: answers the row requested on the previous cycle from the stimulus tables.
    logic [N-1:0]  sp_tab [N];
    logic          rf_tab [N];
    logic [N-1:0]  col_vec;
    logic [AW-1:0] dlc_row = '0;

    always @(posedge clk) if (detection_en) dlc_row <= detection_addr;

    assign single_pe_detection    = sp_tab[dlc_row];
    assign row_fault_detection    = rf_tab[dlc_row];
    assign column_fault_detection = col_vec;

    // Reference model: the map follows directly from the OR rule, counts from $countones.
    logic [N-1:0] exp_map [N];
    int           exp_count;
    logic         exp_raf;

    task automatic build_model();
        exp_count = 0;
        exp_raf   = 1'b0;
        for (int r = 0; r < N; r++) begin
            exp_map[r] = sp_tab[r] | col_vec | (rf_tab[r] ? 8'hFF : 8'h00);
            exp_count += $countones(exp_map[r]);
            if (exp_map[r] == 8'hFF) exp_raf = 1'b1;
        end
    endtask

    function automatic logic exp_parity(input logic [N-1:0] p);
`ifdef FAULT_MAP_PARITY_EN
        return ^p;
`else
        return 1'b0;
`endif
    endfunction

    task automatic clear_tables();
        for (int r = 0; r < N; r++) begin
            sp_tab[r] = '0;
            rf_tab[r] = 1'b0;
        end
        col_vec = '0;
    endtask

    bit           checking = 0;
    int           wr_idx, req_idx, done_cnt;
    logic [N-1:0] seen_pat [N];
    logic         seen_par [N];

    always @(negedge clk) begin
        if (rst_n && checking) begin
            if (envm_wr_en) begin
                check("wr_addr", 32'(envm_wr_addr), 32'(wr_idx % N));
                check("wr_pattern", 32'(envm_faulty_pattern), 32'(exp_map[wr_idx % N]));
                check("wr_parity", 32'(envm_pattern_parity), 32'(exp_parity(exp_map[wr_idx % N])));
                check("busy_in_write", 32'(busy), 32'd1);
                seen_pat[envm_wr_addr] = envm_faulty_pattern;
                seen_par[envm_wr_addr] = envm_pattern_parity;
                wr_idx++;
            end else begin
                check("idle_addr", 32'(envm_wr_addr), 32'd0);
                check("idle_pattern", 32'(envm_faulty_pattern), 32'd0);
                check("idle_parity", 32'(envm_pattern_parity), 32'd0);
            end
            if (detection_en) begin
                check("det_addr", 32'(detection_addr), 32'(req_idx));
                req_idx++;
            end
            if (collect_done) begin
                done_cnt++;
                check("writes_at_done", 32'(wr_idx), 32'(N));
                check("requests_at_done", 32'(req_idx), 32'(N));
                check("fault_count_model", 32'(fault_count), 32'(exp_count));
                check("row_all_faulty_model", 32'(row_all_faulty), 32'(exp_raf));
            end
        end
    end

    // One complete collection; inject_start pulses start again in the middle of the write burst.
    task automatic run_case(input string tag, input int lit_count, input logic lit_raf,
                            input bit inject_start);
        int  t0;
        bit  found;
        build_model();
        check({tag, "_model_count"}, 32'(exp_count), 32'(lit_count));
        wr_idx = 0; req_idx = 0; done_cnt = 0; found = 0;
        checking = 1;
        @(negedge clk);
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (collect_done) found = 1;
            start = inject_start && envm_wr_en && envm_wr_addr == 3'd3;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(found), 32'd1);
        check({tag, "_latency"}, 32'(cyc - t0), 32'd26);
        check({tag, "_fault_count"}, 32'(fault_count), 32'(lit_count));
        check({tag, "_row_all_faulty"}, 32'(row_all_faulty), 32'(lit_raf));
        repeat (3) @(negedge clk);
        check({tag, "_held_count"}, 32'(fault_count), 32'(lit_count));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit found;
        clear_tables();
        build_model();
        repeat (3) @(negedge clk);
        check("reset_wr_en", 32'(envm_wr_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_det_en", 32'(detection_en), 32'd0);
        check("reset_count", 32'(fault_count), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // No faults anywhere.
        run_case("nofault", 0, 1'b0, 0);
        check("nofault_row7", 32'(seen_pat[7]), 32'h00);

        // Single PE fault on row 3, column 2.
        clear_tables();
        sp_tab[3] = 8'h04;
        run_case("single", 1, 1'b0, 0);
        check("single_row3", 32'(seen_pat[3]), 32'h04);
        check("single_row2", 32'(seen_pat[2]), 32'h00);

        // Whole row 5 plus columns 0 and 7 everywhere: 8 + 7*2 = 22.
        clear_tables();
        rf_tab[5] = 1'b1;
        col_vec   = 8'h81;
        run_case("rowcol", 22, 1'b1, 0);
        check("rowcol_row5", 32'(seen_pat[5]), 32'hFF);
        check("rowcol_row0", 32'(seen_pat[0]), 32'h81);
`ifdef FAULT_MAP_PARITY_EN
        check("parity_81", 32'(seen_par[0]), 32'd0);
`else
        check("parity_81", 32'(seen_par[0]), 32'd0);
`endif

        // Parity patterns 07 and 81 in one map; start re-pulsed during WRITE must be ignored.
        clear_tables();
        sp_tab[2] = 8'h07;
        sp_tab[6] = 8'h81;
        run_case("parity", 5, 1'b0, 1);
        check("parity_single_done", 32'(done_cnt), 32'd1);
        repeat (30) @(negedge clk);
        check("parity_no_rerun", 32'(wr_idx), 32'(N));
`ifdef FAULT_MAP_PARITY_EN
        check("parity_07", 32'(seen_par[2]), 32'd1);
`else
        check("parity_07", 32'(seen_par[2]), 32'd0);
`endif
        check("parity_row6", 32'(seen_par[6]), 32'd0);

        // Abort in CAPTURE of row 4, then a clean run must show no stale rows.
        clear_tables();
        col_vec = 8'h81;
        build_model();
        wr_idx = 0; req_idx = 0; done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (detection_en && detection_addr == 3'd4) found = 1;
            else @(negedge clk);
        end
        check("abort_reached_row4", 32'(found), 32'd1);
        @(negedge clk);
        checking = 0;
        rst_n = 1'b0;
        #1;
        check("abort_det_en", 32'(detection_en), 32'd0);
        check("abort_det_addr", 32'(detection_addr), 32'd0);
        check("abort_wr_en", 32'(envm_wr_en), 32'd0);
        check("abort_pattern", 32'(envm_faulty_pattern), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_count", 32'(fault_count), 32'd0);
        check("abort_raf", 32'(row_all_faulty), 32'd0);
        check("abort_done", 32'(collect_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);
        clear_tables();
        run_case("after_abort", 0, 1'b0, 0);
        check("after_abort_row0", 32'(seen_pat[0]), 32'h00);

        checking = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fault_map_collector.md
Name: fault_map_collector

Overview:
- Reads diagnosis results out of the Diagnostic_loop_chains row by row and assembles a per-PE fault map of SYSTOLIC_SIZE x SYSTOLIC_SIZE bits.
- Streams the finished map to eNVM and BISR as one row pattern per cycle, using the same write format that bisr_weight_allocation consumes.
- Sits between the DLC outputs and the eNVM/BISR fault-pattern path. It is started by hybrid_bist after the compared results have been shifted into the DLC.

Parameters:
- SYSTOLIC_SIZE, 8, array dimension; number of rows and number of PEs per row.
- ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), row address width.
- CNT_WIDTH, $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1), width of the fault counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse that begins collection; ignored unless in IDLE.
- detection_en  output  1  request to the DLC; high while a row address is being presented.
- detection_addr  output  ADDR_WIDTH  row currently being requested from the DLC.
- single_pe_detection  input  SYSTOLIC_SIZE  per-column single-PE fault bits for the requested row, valid 1 cycle after the request.
- row_fault_detection  input  1  whole-row fault for the requested row, valid 1 cycle after the request.
- column_fault_detection  input  SYSTOLIC_SIZE  column-fault vector, valid 1 cycle after the request.
- envm_wr_en  output  1  write strobe for one fault-pattern row.
- envm_wr_addr  output  ADDR_WIDTH  row index of the current write.
- envm_faulty_pattern  output  SYSTOLIC_SIZE  fault bits for that row; bit c = 1 means PE(row,c) is faulty.
- envm_pattern_parity  output  1  even parity of envm_faulty_pattern (see Optional Feature).
- fault_count  output  CNT_WIDTH  total number of faulty PEs in the map; valid from DONE onward.
- row_all_faulty  output  1  sticky flag; set if any row is entirely faulty.
- busy  output  1  high in every state except IDLE.
- collect_done  output  1  one-cycle pulse when the last row has been written.

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and the map registers are cleared. Reset asserted mid-operation aborts immediately; no partial write completes.
- FSM states: IDLE, REQ, CAPTURE, WRITE, DONE.
- IDLE:
  - start=1 moves to REQ, clears the map, clears fault_count and row_all_faulty, and sets the row counter r to 0.
  - start in any other state is ignored.
- REQ:
  - detection_en=1 and detection_addr=r.
  - Next state is CAPTURE.
- CAPTURE:
  - detection_en=0.
  - Latches map[r] = single_pe_detection | column_fault_detection | {SYSTOLIC_SIZE{row_fault_detection}}.
  - If r = SYSTOLIC_SIZE-1, go to WRITE with r reset to 0. Otherwise increment r and return to REQ.
  - Each row therefore costs 2 cycles; collection takes 2*SYSTOLIC_SIZE cycles.
- WRITE:
  - envm_wr_en=1 for exactly SYSTOLIC_SIZE consecutive cycles.
  - Each cycle drives envm_wr_addr=r and envm_faulty_pattern=map[r], then increments r.
  - fault_count accumulates popcount(map[r]) on each write.
  - row_all_faulty is set when map[r] is all ones.
  - After the last row, go to DONE.
- DONE:
  - collect_done=1 for one cycle.
  - fault_count and row_all_faulty hold their values until the next start.
  - Next state is IDLE.
- When envm_wr_en=0, envm_faulty_pattern and envm_wr_addr are 0.
- Arithmetic rules:
  - popcount is unsigned.
  - fault_count cannot overflow, because the maximum is SYSTOLIC_SIZE^2 and CNT_WIDTH covers it.
  - The row counter wraps only through the explicit reset to 0; it never reaches SYSTOLIC_SIZE.
- Total latency from start to collect_done is 3*SYSTOLIC_SIZE+2 cycles.

Optional Feature:
- Macro: FAULT_MAP_PARITY_EN.
- Defined:
  - envm_pattern_parity = ^envm_faulty_pattern, registered alongside the pattern. It is 0 when envm_wr_en=0.
  - A parity_error_inject debug register is not provided.
- Undefined: envm_pattern_parity is tied to 0 and no parity logic is synthesised.

Test Plan (SYSTOLIC_SIZE=8):
- No faults: start with all DLC inputs 0 -> 8 writes of 8'h00 at addresses 0..7, fault_count=0, row_all_faulty=0, collect_done exactly 26 cycles after start.
- Single PE fault: single_pe_detection=8'h04 only when detection_addr=3 -> write at address 3 is 8'h04, all other rows 8'h00, fault_count=1.
- Row and column faults: row_fault_detection=1 for row 5, column_fault_detection=8'h81 on every row -> row 5 = 8'hFF, other rows = 8'h81, fault_count=22, row_all_faulty=1.
- start pulsed during WRITE -> ignored; sequence completes normally, with one collect_done.
- rst_n deasserted during CAPTURE of row 4 -> all outputs 0 asynchronously and FSM in IDLE; a new start yields a clean map with no stale row data.
- With FAULT_MAP_PARITY_EN defined, pattern 8'h07 -> envm_pattern_parity=1; pattern 8'h81 -> 0. With the macro undefined, parity is always 0.
